uart_reg_ctrl: RTL

Byte-command controller between the UART receiver and transmitter of the board-test design. It parses commands arriving on the receiver's AXI-stream output and reads or writes a small register file that drives the LEDs. It returns exactly one response byte per complete command on the transmitter's AXI-stream input. It replaces the direct rx→tx loopback and applies backpressure to the receiver while a response is pending.

---
 rtl/uart_reg_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_reg_ctrl.sv
// Byte-command controller between the UART receiver and transmitter: parses
// 'W'/'R' commands, accesses a small register file and returns one response byte.
module uart_reg_ctrl #(
    parameter int          CLK_FREQ       = 100_000_000,
    parameter int          TIMEOUT_CYCLES = CLK_FREQ / 10,
    parameter logic [7:0]  ID_VALUE       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_rx_tdata,
    input  logic       uart_rx_tvalid,
    output logic       uart_rx_tready,
    output logic [7:0] axis_tdata,
    output logic       axis_tvalid,
    input  logic       axis_tready,
    input  logic [7:0] status_in,
    output logic [7:0] leds
);

    // state    | meaning
    // IDLE     | waiting for an opcode byte
    // GET_ADDR | opcode latched, waiting for the address byte
    // GET_DATA | write address latched, waiting for the data byte
    // RESP     | response byte presented to the transmitter

    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] RESP_OK   = 8'h4B;
    localparam logic [7:0] RESP_ERR  = 8'h45;
    localparam logic [7:0] RESP_UNK  = 8'h3F;

    localparam logic [7:0] ADDR_LED     = 8'h00;
    localparam logic [7:0] ADDR_SCRATCH = 8'h01;
    localparam logic [7:0] ADDR_STATUS  = 8'h02;
    localparam logic [7:0] ADDR_ID      = 8'h03;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_ADDR = 2'd1,
        GET_DATA = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_wr_q, op_wr_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       resp_q, resp_d;
    logic [7:0]       led_q, led_d;
    logic [7:0]       scratch_q, scratch_d;
    logic             rx_en_q;

    logic             rx_fire;
    logic             tx_fire;
    logic [7:0]       rd_data;

    // rx_en_q keeps tready low through reset and for the first cycle after it
    assign uart_rx_tready = rx_en_q && (state_q != RESP);
    assign axis_tvalid    = (state_q == RESP);
    assign axis_tdata     = resp_q;
    assign leds           = led_q;

    assign rx_fire = uart_rx_tvalid && uart_rx_tready;
    assign tx_fire = axis_tvalid && axis_tready;

    // Read data is looked up from the incoming address byte, so status_in is
    // captured on the same edge that accepts the address.
    always_comb begin
        rd_data = RESP_ERR;
        unique case (uart_rx_tdata)
            ADDR_LED:     rd_data = led_q;
            ADDR_SCRATCH: rd_data = scratch_q;
            ADDR_STATUS:  rd_data = status_in;
            ADDR_ID:      rd_data = ID_VALUE;
            default:      rd_data = RESP_ERR;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        resp_d    = resp_q;
        led_d     = led_q;
        scratch_d = scratch_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_fire) begin
                    if (uart_rx_tdata == OP_WRITE) begin
                        op_wr_d = 1'b1;
                        state_d = GET_ADDR;
                    end else if (uart_rx_tdata == OP_READ) begin
                        op_wr_d = 1'b0;
                        state_d = GET_ADDR;
                    end else begin
                        resp_d  = RESP_UNK;
                        state_d = RESP;
                    end
                end
            end

            GET_ADDR: begin
                if (rx_fire) begin
                    cnt_d  = '0;
                    addr_d = uart_rx_tdata;
                    if (op_wr_q) begin
                        state_d = GET_DATA;
                    end else begin
                        resp_d  = rd_data;
                        state_d = RESP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            GET_DATA: begin
                if (rx_fire) begin
                    cnt_d   = '0;
                    state_d = RESP;
                    if (addr_q == ADDR_LED) begin
                        led_d  = uart_rx_tdata;
                        resp_d = RESP_OK;
                    end else if (addr_q == ADDR_SCRATCH) begin
                        scratch_d = uart_rx_tdata;
                        resp_d    = RESP_OK;
                    end else begin
                        resp_d = RESP_ERR;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            RESP: begin
                cnt_d = '0;
                if (tx_fire) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
            addr_q    <= 8'h00;
            resp_q    <= 8'h00;
            led_q     <= 8'h00;
            scratch_q <= 8'h00;
            rx_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            resp_q    <= resp_d;
            led_q     <= led_d;
            scratch_q <= scratch_d;
            rx_en_q   <= 1'b1;
        end
    end

endmodule
